// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage: fixed-latency MULT/MULTU/DIV/DIVU with
// private HI/LO registers, plus single-cycle MTHI/MTLO writes.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        req,
  output logic        in_ready,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  // Handshake: start with an arithmetic md_op is the request, in_ready is the
  // acceptance; an operation transfers on the rising edge where both are high
  // and req is low. The hazard unit holds MD instructions in D while in_ready=0.

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_lo_q;
  logic        pend_ok_q;
  logic        launch, commit;

  logic        is_mult, is_div, b_nz;
  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, b_div, q_mag, r_mag, q_s, r_s, b_udiv, q_u, r_u;
  logic [31:0] res_hi, res_lo;

  assign is_mult = (md_op == 3'd1) || (md_op == 3'd2);
  assign is_div  = (md_op == 3'd3) || (md_op == 3'd4);
  assign b_nz    = (B != 32'd0);

  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 r 0.
  assign a_mag  = A[31] ? (~A + 32'd1) : A;
  assign b_mag  = B[31] ? (~B + 32'd1) : B;
  assign b_div  = b_nz ? b_mag : 32'd1;
  assign q_mag  = a_mag / b_div;
  assign r_mag  = a_mag % b_div;
  assign q_s    = (A[31] ^ B[31]) ? (~q_mag + 32'd1) : q_mag;
  assign r_s    = A[31] ? (~r_mag + 32'd1) : r_mag;
  assign b_udiv = b_nz ? B : 32'd1;
  assign q_u    = A / b_udiv;
  assign r_u    = A % b_udiv;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (md_op)
      3'd1:    begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
      3'd2:    begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
      3'd3:    begin res_hi = r_s;           res_lo = q_s;          end
      3'd4:    begin res_hi = r_u;           res_lo = q_u;          end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    launch  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (is_mult || is_div) && !req) begin
          launch  = 1'b1;
          state_d = BUSY;
          cnt_d   = is_mult ? MULT_N : DIV_N;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd1) begin
          commit  = 1'b1;
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_ok_q <= 1'b0;
    end else if (launch) begin
      pend_hi_q <= res_hi;
      pend_lo_q <= res_lo;
      pend_ok_q <= is_mult || b_nz;
    end
  end

  // MTHI/MTLO only land while idle; the hazard unit never issues them when busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      HI <= 32'd0;
      LO <= 32'd0;
    end else if (commit) begin
      if (pend_ok_q) begin
        HI <= pend_hi_q;
        LO <= pend_lo_q;
      end
    end else if (state_q == IDLE && !req) begin
      if (md_op == 3'd5) HI <= A;
      if (md_op == 3'd6) LO <= A;
    end
  end

  assign in_ready = (state_q == IDLE);

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: latency, arithmetic results, divide-by-zero,
// flush, restart-while-busy, back-to-back launch and mid-operation reset.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        req = 1'b0;
  logic        in_ready;
  logic [31:0] HI, LO;

  int checks = 0;
  int passes = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .A(A), .B(B),
    .req(req), .in_ready(in_ready), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  // Called at a negedge; inputs are consumed by the following posedge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = (op >= 3'd1 && op <= 3'd4);
    md_op = op; A = a; B = b; req = 1'b0;
    @(negedge clk);
    start = 1'b0; md_op = 3'd0; A = 32'd0; B = 32'd0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b exp 1", in_ready); else passes++;
    checks++; if (HI !== 32'd0) $display("FAIL reset_hi: got %h exp 0", HI); else passes++;
    checks++; if (LO !== 32'd0) $display("FAIL reset_lo: got %h exp 0", LO); else passes++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult;
    int n;
    issue(3'd1, 32'd3, 32'hFFFFFFFE);
    wait_idle(n);
    checks++; if (n != 5) $display("FAIL mult_busy: got %0d exp 5", n); else passes++;
    checks++; if (HI !== 32'hFFFFFFFF) $display("FAIL mult_hi: got %h exp ffffffff", HI); else passes++;
    checks++; if (LO !== 32'hFFFFFFFA) $display("FAIL mult_lo: got %h exp fffffffa", LO); else passes++;
  endtask

  task automatic test_multu;
    int n;
    issue(3'd2, 32'hFFFFFFFF, 32'd2);
    wait_idle(n);
    checks++; if (n != 5) $display("FAIL multu_busy: got %0d exp 5", n); else passes++;
    checks++; if (HI !== 32'h00000001) $display("FAIL multu_hi: got %h exp 00000001", HI); else passes++;
    checks++; if (LO !== 32'hFFFFFFFE) $display("FAIL multu_lo: got %h exp fffffffe", LO); else passes++;
  endtask

  task automatic test_div;
    int n;
    issue(3'd3, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    checks++; if (n != 10) $display("FAIL div_busy: got %0d exp 10", n); else passes++;
    checks++; if (LO !== 32'hFFFFFFFD) $display("FAIL div_lo: got %h exp fffffffd", LO); else passes++;
    checks++; if (HI !== 32'hFFFFFFFF) $display("FAIL div_hi: got %h exp ffffffff", HI); else passes++;
    issue(3'd4, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    checks++; if (n != 10) $display("FAIL divu_busy: got %0d exp 10", n); else passes++;
    checks++; if (LO !== 32'h7FFFFFFC) $display("FAIL divu_lo: got %h exp 7ffffffc", LO); else passes++;
    checks++; if (HI !== 32'h00000001) $display("FAIL divu_hi: got %h exp 00000001", HI); else passes++;
    issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    checks++; if (LO !== 32'h80000000) $display("FAIL div_ovf_lo: got %h exp 80000000", LO); else passes++;
    checks++; if (HI !== 32'h00000000) $display("FAIL div_ovf_hi: got %h exp 00000000", HI); else passes++;
  endtask

  task automatic test_div_zero;
    int n;
    issue(3'd5, 32'h1234, 32'd0);
    checks++; if (in_ready !== 1'b1) $display("FAIL mthi_ready: got %b exp 1", in_ready); else passes++;
    issue(3'd6, 32'h5678, 32'd0);
    checks++; if (HI !== 32'h1234) $display("FAIL mthi_hi: got %h exp 00001234", HI); else passes++;
    checks++; if (LO !== 32'h5678) $display("FAIL mtlo_lo: got %h exp 00005678", LO); else passes++;
    issue(3'd4, 32'd7, 32'd0);
    wait_idle(n);
    checks++; if (n != 10) $display("FAIL divz_busy: got %0d exp 10", n); else passes++;
    checks++; if (HI !== 32'h1234) $display("FAIL divz_hi: got %h exp 00001234", HI); else passes++;
    checks++; if (LO !== 32'h5678) $display("FAIL divz_lo: got %h exp 00005678", LO); else passes++;
  endtask

  task automatic test_flush;
    start = 1'b1; md_op = 3'd1; A = 32'd3; B = 32'd9; req = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) $display("FAIL flush_ready: got %b exp 1", in_ready); else passes++;
    start = 1'b0; md_op = 3'd5; A = 32'hDEAD;
    @(negedge clk);
    md_op = 3'd0; A = 32'd0; B = 32'd0; req = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (in_ready !== 1'b1) $display("FAIL flush_idle: got %b exp 1", in_ready); else passes++;
    checks++; if (HI !== 32'h1234) $display("FAIL flush_hi: got %h exp 00001234", HI); else passes++;
    checks++; if (LO !== 32'h5678) $display("FAIL flush_lo: got %h exp 00005678", LO); else passes++;
  endtask

  task automatic test_restart;
    int n;
    issue(3'd1, 32'd100, 32'd7);
    @(negedge clk);
    start = 1'b1; md_op = 3'd1; A = 32'd5; B = 32'd5;
    @(negedge clk);
    start = 1'b0; md_op = 3'd0; A = 32'd0; B = 32'd0;
    wait_idle(n);
    n = n + 2;
    checks++; if (n != 5) $display("FAIL restart_busy: got %0d exp 5", n); else passes++;
    checks++; if (LO !== 32'd700) $display("FAIL restart_lo: got %h exp 000002bc", LO); else passes++;
    checks++; if (HI !== 32'd0) $display("FAIL restart_hi: got %h exp 00000000", HI); else passes++;
  endtask

  task automatic test_back_to_back;
    int n;
    issue(3'd2, 32'd6, 32'd7);
    wait_idle(n);
    checks++; if (LO !== 32'd42) $display("FAIL b2b_first_lo: got %h exp 0000002a", LO); else passes++;
    issue(3'd2, 32'd42, 32'd2);
    checks++; if (in_ready !== 1'b0) $display("FAIL b2b_accept: got %b exp 0", in_ready); else passes++;
    wait_idle(n);
    n = n;
    checks++; if (n != 5) $display("FAIL b2b_busy: got %0d exp 5", n); else passes++;
    checks++; if (LO !== 32'd84) $display("FAIL b2b_lo: got %h exp 00000054", LO); else passes++;
  endtask

  task automatic test_reset_mid;
    issue(3'd3, 32'd100, 32'd7);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL rstmid_ready: got %b exp 1", in_ready); else passes++;
    checks++; if (HI !== 32'd0) $display("FAIL rstmid_hi: got %h exp 0", HI); else passes++;
    checks++; if (LO !== 32'd0) $display("FAIL rstmid_lo: got %h exp 0", LO); else passes++;
    @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    checks++; if (LO !== 32'd0) $display("FAIL rstmid_nocommit_lo: got %h exp 0", LO); else passes++;
    checks++; if (HI !== 32'd0) $display("FAIL rstmid_nocommit_hi: got %h exp 0", HI); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL rstmid_idle: got %b exp 1", in_ready); else passes++;
  endtask

  initial begin
    test_reset;
    test_mult;
    test_multu;
    test_div;
    test_div_zero;
    test_flush;
    test_restart;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
